muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Iterative multi-cycle multiply/divide engine beside the execute-stage ALU, handling RV32M ops the single-cycle ALU cannot.
- Sequences one operation at a time and holds the front of the pipeline via a stall request until the result is ready.
- Presents the result and destination register for merge into the execute→memory pipeline register.
- Honours the data-cache stall exactly as the execute stage does.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-low reset
- md_start  in  1  decode presents an M-extension op this cycle
- md_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- md_write_sel  in  5  destination register of the op
- md_a  in  XLEN  operand rs1, already bypassed
- md_b  in  XLEN  operand rs2, already bypassed
- dcache_stall  in  1  global freeze from data cache
- md_busy  out  1  state != IDLE
- md_stall  out  1  hold decode/execute registers
- md_done  out  1  result valid this cycle
- md_result  out  XLEN  final result
- md_write_sel_out  out  5  destination captured at start

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; all outputs 0; internal accumulators, counter and registers 0.
  - Reset wins over every other input, including mid-operation; any in-flight op is discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On md_start && !dcache_stall: latch op, write_sel, operand magnitudes and sign flags (signed ops only); counter=0.
  - Next state is CALC, except special divide cases (below), which go straight to DONE.
  - md_start while dcache_stall: ignored; decode keeps presenting it.
- CALC, one iteration per cycle while !dcache_stall:
  - Multiply: radix-2 shift-add, 2*XLEN product.
  - Divide: restoring, one quotient bit per cycle.
  - After XLEN iterations (counter==XLEN-1 at the edge) go to DONE.
  - dcache_stall freezes the counter and all datapath registers.
- DONE:
  - md_done=1 and md_result valid.
  - Sign fix-up is applied when DONE is entered, so md_result is registered.
  - Return to IDLE at the first edge with !dcache_stall; while stalled, DONE holds with md_done=1.
- Result selection:
  - MUL: product[31:0]; MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient; REM/REMU: remainder.
  - Signed ops negate magnitudes per RV32M sign rules; the remainder takes the dividend's sign.
- Special cases, resolved in the start cycle with a 1-cycle path to DONE:
  - Divide by zero: quotient=32'hFFFFFFFF, remainder=md_a.
  - Signed overflow (md_a=32'h80000000, md_b=32'hFFFFFFFF): DIV=32'h80000000, REM=0.
- md_stall = (state==IDLE && md_start) || state==CALC.
  - Deasserted in DONE, so the pipeline advances exactly once with md_done=1.
  - Decode must drop md_start for that instruction on the same edge.
- Latency, start cycle = cycle 0 with no dcache_stall:
  - Normal op: md_done high in cycle XLEN+1 (33).
  - Special case: md_done high in cycle 1.
- Back-to-back start: md_start is only sampled in IDLE. A new op presented during DONE waits one cycle (IDLE), then starts.
- md_write_sel_out holds the latched value from start until the next accepted start.

Decomposition:
- Shared package:
  - md_op encodings (MD_MUL…MD_REMU).
  - FSM state encodings.
  - XLEN constant.
  - Constants 32'h80000000 and 32'hFFFFFFFF.
- One natural sub-module, muldiv_datapath: shift/add/subtract iteration registers and sign fix-up.
- The FSM, counter and stall logic remain in muldiv_sequencer.

Test Plan:
- MUL 7 × -3 (md_a=7, md_b=32'hFFFFFFFD) → md_stall high cycles 0–32; md_done in cycle 33 with md_result=32'hFFFFFFEB.
- MULHU 32'hFFFFFFFF × 32'hFFFFFFFF → md_result=32'hFFFFFFFE; MULH same operands → 0.
- DIV -7 / 2 → 32'hFFFFFFFD; REM -7 / 2 → 32'hFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → md_done in cycle 1, md_result=32'hFFFFFFFF; REM 5 / 0 → 5; DIV 32'h80000000 / -1 → 32'h80000000, REM → 0, both in cycle 1.
- dcache_stall high for 4 cycles mid-CALC, then 2 cycles in DONE → md_done delayed to cycle 37, held high across the stall, result unchanged.
- reset low in CALC cycle 10 → next cycle state IDLE and all outputs 0; a new MUL 3×4 then completes normally with result 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the multiply/divide sequencer
package muldiv_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = 6;

    localparam logic [MD_XLEN-1:0] MD_INT_MIN  = 32'h80000000;
    localparam logic [MD_XLEN-1:0] MD_ALL_ONES = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift-add multiply / restoring divide iteration and sign fix-up
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            finish,
    input  md_op_t          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            special,
    output logic [XLEN-1:0] result
);

    logic            a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, overflow;
    logic [XLEN-1:0] special_res;

    md_op_t          op_q;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] hi, lo, opnd;

    logic [XLEN:0]     sum, shifted;
    logic [XLEN-1:0]   diff;
    logic              ge;
    logic [XLEN-1:0]   hi_nxt, lo_nxt;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    // MUL ignores signs: the low half of the product is identical either way.
    always_comb begin
        a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
        b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
        sa       = a_signed && a[XLEN-1];
        sb       = b_signed && b[XLEN-1];
        a_mag    = sa ? -a : a;
        b_mag    = sb ? -b : b;
        div_zero = op[2] && (b == '0);
        overflow = ((op == MD_DIV) || (op == MD_REM)) && (a == MD_INT_MIN) && (b == MD_ALL_ONES);
        special  = div_zero || overflow;
        if (div_zero)
            special_res = op[1] ? a : MD_ALL_ONES;
        else
            special_res = (op == MD_DIV) ? MD_INT_MIN : '0;
    end

    // hi: partial product / remainder, lo: multiplier / dividend becoming quotient.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[XLEN-1]};
        ge      = shifted >= {1'b0, opnd};
        diff    = shifted[XLEN-1:0] - opnd;
        if (op_q[2]) begin
            hi_nxt = ge ? diff : shifted[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ge};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end

    always_comb begin
        prod     = {hi_nxt, lo_nxt};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -lo_nxt : lo_nxt;
        rem_fix  = neg_r ? -hi_nxt : hi_nxt;
        case (op_q)
            MD_MUL:                         fix_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:   fix_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:                fix_res = quo_fix;
            default:                        fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            op_q   <= MD_MUL;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            result <= '0;
        end else if (load) begin
            op_q  <= op;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            hi    <= '0;
            lo    <= a_mag;
            opnd  <= b_mag;
            if (special)
                result <= special_res;
        end else if (step) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
            if (finish)
                result <= fix_res;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide engine with pipeline stall control
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            md_start,
    input  logic [2:0]      md_op,
    input  logic [4:0]      md_write_sel,
    input  logic [XLEN-1:0] md_a,
    input  logic [XLEN-1:0] md_b,
    input  logic            dcache_stall,
    output logic            md_busy,
    output logic            md_stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result,
    output logic [4:0]      md_write_sel_out
);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             load, step, finish, special;

    assign load   = (state == ST_IDLE) && md_start && !dcache_stall;
    assign step   = (state == ST_CALC) && !dcache_stall;
    assign finish = step && (count == CNT_W'(XLEN - 1));

    always_ff @(posedge clock) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (load)          state_nxt = special ? ST_DONE : ST_CALC;
            ST_CALC: if (finish)        state_nxt = ST_DONE;
            ST_DONE: if (!dcache_stall) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // md_stall drops in DONE so the pipeline advances exactly once with the result.
    always_comb begin
        md_busy  = (state != ST_IDLE);
        md_stall = ((state == ST_IDLE) && md_start) || (state == ST_CALC);
        md_done  = (state == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count            <= '0;
            md_write_sel_out <= '0;
        end else if (load) begin
            count            <= '0;
            md_write_sel_out <= md_write_sel;
        end else if (step) begin
            count <= count + 1'b1;
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .finish  (finish),
        .op      (md_op_t'(md_op)),
        .a       (md_a),
        .b       (md_b),
        .special (special),
        .result  (md_result)
    );

endmodule
